// File: rtl/verin_adc_acq_pkg.sv
// Shared types and defaults for the actuator ADC acquisition stage.
package verin_pkg;

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} acq_state_t;

  localparam int DEF_CLK_DIV     = 25;
  localparam int DEF_DATA_W      = 12;
  localparam int DEF_NULL_BITS   = 3;
  localparam int DEF_CONV_PERIOD = 50000;
  localparam int AVG_DEPTH       = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// ADC serial clock generator: CLK_DIV-cycle half periods, high phase first,
// held cleared while the acquisition FSM is outside SHIFT.
module adc_sclk_gen import verin_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,        // FSM is in SHIFT this cycle
  input  logic run_next,   // FSM will be in SHIFT next cycle
  output logic clk_adc,
  output logic rise,       // cycle in which clk_adc has just gone high
  output logic period_end  // last cycle of a low phase
);

  localparam int HW = cw(CLK_DIV);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          phase_q, phase_d;   // 0 = high half, 1 = low half
  logic          clk_adc_q, clk_adc_d;
  logic          half_end;

  assign half_end = (hcnt_q == HW'(CLK_DIV - 1));

  // clk_adc is registered from the next-cycle phase so the first SHIFT
  // cycle already sees the line high.
  always_comb begin
    hcnt_d  = '0;
    phase_d = 1'b0;
    if (run) begin
      hcnt_d  = half_end ? '0 : hcnt_q + 1'b1;
      phase_d = phase_q ^ half_end;
    end
    clk_adc_d = run_next & ~phase_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q    <= '0;
      phase_q   <= 1'b0;
      clk_adc_q <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      phase_q   <= phase_d;
      clk_adc_q <= clk_adc_d;
    end
  end

  assign clk_adc    = clk_adc_q;
  assign rise       = run & ~phase_q & (hcnt_q == '0);
  assign period_end = run &  phase_q & half_end;

endmodule

// File: rtl/verin_adc_acq.sv
// Periodic MCP3201-class serial ADC read for the actuator position loop.
// Define ADC_AVG_EN to present a 4-deep sliding-window average instead of raw results.
module verin_adc_acq import verin_pkg::*; #(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NULL_BITS   = DEF_NULL_BITS,
  parameter int CONV_PERIOD = DEF_CONV_PERIOD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              data_adc,
  output logic              clk_adc,
  output logic              cs_n,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy
);

  localparam int NBITS = NULL_BITS + DATA_W;
  localparam int PW    = cw(CONV_PERIOD);
  localparam int TW    = cw(CLK_DIV);
  localparam int BW    = cw(NBITS);

  acq_state_t        state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              tick, conv_done, rise, period_end;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (state_q == SHIFT),
    .run_next   (state_d == SHIFT),
    .clk_adc    (clk_adc),
    .rise       (rise),
    .period_end (period_end)
  );

  assign tick = enable && (pcnt_q == PW'(CONV_PERIOD - 1));

  always_comb begin
    state_d   = state_q;
    pcnt_d    = enable ? (tick ? '0 : pcnt_q + 1'b1) : '0;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    conv_done = 1'b0;
    case (state_q)
      // A tick outside IDLE is simply dropped; nothing is queued.
      IDLE: if (tick) begin
        state_d = CS_SETUP;
        tcnt_d  = '0;
      end
      CS_SETUP: begin
        if (tcnt_q == TW'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          tcnt_d  = '0;
          bcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (rise && bcnt_q >= BW'(NULL_BITS))
          shreg_d = {shreg_q[DATA_W-2:0], data_adc};
        if (period_end) begin
          if (bcnt_q == BW'(NBITS - 1)) begin
            state_d   = CS_HOLD;
            bcnt_d    = '0;
            conv_done = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (tcnt_q == TW'(CLK_DIV - 1)) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cs_n_d = !(state_d == CS_SETUP || state_d == SHIFT);
    busy_d = (state_d != IDLE);
  end

`ifdef ADC_AVG_EN
  localparam int AW = cw(AVG_DEPTH);
  localparam int FW = cw(AVG_DEPTH + 1);
  localparam int SW = DATA_W + AW;

  logic [DATA_W-1:0] ring_q [AVG_DEPTH];
  logic [DATA_W-1:0] ring_d [AVG_DEPTH];
  logic [SW-1:0]     sum_q, sum_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [FW-1:0]     fill_q, fill_d;

  // Running sum: add the newest result, drop the one it overwrites.
  always_comb begin
    ring_d   = ring_q;
    sum_d    = sum_q;
    wp_d     = wp_q;
    fill_d   = fill_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (conv_done) begin
      sum_d        = sum_q + SW'(shreg_q) - SW'(ring_q[wp_q]);
      ring_d[wp_q] = shreg_q;
      wp_d         = (wp_q == AW'(AVG_DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (fill_q != FW'(AVG_DEPTH)) fill_d = fill_q + 1'b1;
      if (fill_d == FW'(AVG_DEPTH)) begin
        sample_d = sum_d[SW-1:AW];
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
      sum_q  <= '0;
      wp_q   <= '0;
      fill_q <= '0;
    end else begin
      ring_q <= ring_d;
      sum_q  <= sum_d;
      wp_q   <= wp_d;
      fill_q <= fill_d;
    end
  end
`else
  always_comb begin
    sample_d = conv_done ? shreg_q : sample_q;
    valid_d  = conv_done;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
    end
  end

  assign cs_n         = cs_n_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule
